// File: rtl/aes_pkg.sv
// Shared AES constants, the InvShiftRows byte-index map and the inverse-round FSM type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Byte ordering: state bits [0:127], byte i = bits [8i +: 8], row = i mod 4, column = i div 4.
package aes_pkg;

    localparam int STATE_W   = 128;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = STATE_W / BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } inv_round_state_e;

    // Index of the input byte that lands in output byte idx after InvShiftRows:
    // out byte (r + 4c) = in byte (r + 4*((c - r) mod 4)).
    function automatic int unsigned inv_shift_rows_src(input int unsigned idx);
        int unsigned r;
        int unsigned c;
        r = idx % 4;
        c = idx / 4;
        return r + 4 * ((c + 4 - r) % 4);
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box, one byte in, one byte out.
// Latency: 0 cycles (pure lookup).
// Backpressure: none, no state.
// Ports: address = byte to substitute, sbox_data = InvSubBytes(address).
module inv_sbox (
    input  logic [7:0] address,
    output logic [7:0] sbox_data
);

    // Element 0 is the leftmost byte of the first row.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign sbox_data = INV_SBOX[address];

endmodule

// File: rtl/inv_shift_sub_rows.sv
// Iterative InvShiftRows + InvSubBytes stage: permutes on accept, then substitutes LANES bytes per cycle.
// Latency: accept at edge T, out_valid after edge T + 16/LANES (same for sub_en 0 and 1).
// Backpressure: single-entry; in_ready only in IDLE, DONE holds out_state until out_ready.
// Ports: clk/reset (sync, active-high); in_valid/in_ready/in_state/in_sub_en input handshake;
//        out_valid/out_ready/out_state output handshake. LANES = parallel inv_sbox count (1,2,4,8,16).
module inv_shift_sub_rows
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:STATE_W-1] in_state,
    input  logic               in_sub_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:STATE_W-1] out_state
);

    localparam int NSTEP = NUM_BYTES / LANES;
    localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEP - 1);

    inv_round_state_e   fsm_q, fsm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sub_en_q, sub_en_d;
    logic [0:STATE_W-1] state_q, state_d;

    logic [0:STATE_W-1] shifted;
    logic [BYTE_W-1:0]  lane_in  [LANES];
    logic [BYTE_W-1:0]  lane_out [LANES];

    // InvShiftRows is pure wiring, applied as the state is captured.
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_isr
        localparam int SRC = int'(inv_shift_rows_src(i));
        assign shifted[BYTE_W*i +: BYTE_W] = in_state[BYTE_W*SRC +: BYTE_W];
    end

    // Lane l handles byte LANES*cnt + l of the current window.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = state_q[BYTE_W*(LANES*int'(cnt_q) + l) +: BYTE_W];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        inv_sbox u_inv_sbox (
            .address   (lane_in[l]),
            .sbox_data (lane_out[l])
        );
    end

    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        sub_en_d = sub_en_q;
        state_d  = state_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = shifted;
                    sub_en_d = in_sub_en;
                    cnt_d    = '0;
                    fsm_d    = SUB;
                end
            end
            SUB: begin
                // Window still walks when sub_en is 0 so the cycle count is data-independent.
                if (sub_en_q) begin
                    for (int l = 0; l < LANES; l++) begin
                        state_d[BYTE_W*(LANES*int'(cnt_q) + l) +: BYTE_W] = lane_out[l];
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q    <= IDLE;
            cnt_q    <= '0;
            sub_en_q <= 1'b0;
            state_q  <= '0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            sub_en_q <= sub_en_d;
            state_q  <= state_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign out_state = state_q;

endmodule

// File: tb/tb_inv_shift_sub_rows.sv
// Scoreboard bench for inv_shift_sub_rows: directed vectors, random blocks, backpressure, resets, LANES sweep.
// Latency: checked per accepted block against 16/LANES.
// Backpressure: random and directed out_ready stalls; held output must stay stable.
module tb_inv_shift_sub_rows;

    localparam int LANES = 4;
    localparam int NCYC  = 16 / LANES;
    localparam int SW_L [4] = '{1, 2, 8, 16};

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_sub_en;
    logic         out_valid, out_ready;
    logic [0:127] in_state, out_state;

    logic         sw_vld, sw_sub;
    logic [0:127] sw_st;
    logic         sw_irdy [4];
    logic         sw_ovld [4];
    logic [0:127] sw_out  [4];

    int           tests = 0;
    int           fails = 0;
    logic [0:127] exp_q [$];
    logic [7:0]   inv_tab [256];
    logic         rand_ordy;
    int           sw_lat [4];
    logic [0:127] sw_got [4];

    always #5 clk = ~clk;

    inv_shift_sub_rows #(.LANES(LANES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_sub_en (in_sub_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sw
        inv_shift_sub_rows #(.LANES(SW_L[g])) u_sw (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (sw_vld),
            .in_ready  (sw_irdy[g]),
            .in_state  (sw_st),
            .in_sub_en (sw_sub),
            .out_valid (sw_ovld[g]),
            .out_ready (1'b1),
            .out_state (sw_out[g])
        );
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Forward S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [0:127] model(input logic [0:127] s, input logic sub);
        logic [7:0]   ib [16];
        logic [7:0]   b;
        logic [0:127] o;
        o = '0;
        for (int i = 0; i < 16; i++) ib[i] = s[8*i +: 8];
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                b = ib[r + 4*((c - r + 4) % 4)];
                o[8*(r + 4*c) +: 8] = sub ? inv_tab[b] : b;
            end
        end
        return o;
    endfunction

    // Called at posedge+1; returns at posedge+1 once out_valid is seen.
    task automatic send(input logic [0:127] s, input logic sub, input logic [0:127] exp);
        int n;
        int lat;
        in_state = s; in_sub_en = sub; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready 0 after %0d cycles, required 1", n);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_state  = {$urandom, $urandom, $urandom, $urandom};
        in_sub_en = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, NCYC);
    endtask

    // Monitor: pops on every output transfer and checks hold stability under backpressure.
    initial begin
        logic         hold;
        logic [0:127] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_stable", out_state, held);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_output: got %h, required no transfer", out_state);
                    end else begin
                        check("out_state", out_state, exp_q.pop_front());
                    end
                end
                hold = out_valid && !out_ready;
                held = out_state;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #2;
            if (rand_ordy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:127] s, e;
        logic         sb;
        int           n;
        reset = 1'b1; in_valid = 1'b0; in_state = '0; in_sub_en = 1'b0; out_ready = 1'b0;
        sw_vld = 1'b0; sw_st = '0; sw_sub = 1'b0; rand_ordy = 1'b0;
        for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_state", out_state, 0);
        reset = 1'b0;
        out_ready = 1'b1;

        // Directed vectors.
        send(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h000d0a0704010e0b0805020f0c090603);
        send({16{8'h63}}, 1'b1, '0);
        send('0, 1'b1, {16{8'h52}});
        send({8{16'h7c63}}, 1'b1, {8{16'h0100}});

        // Random blocks with random backpressure.
        rand_ordy = 1'b1;
        for (int k = 0; k < 30; k++) begin
            s  = {$urandom, $urandom, $urandom, $urandom};
            sb = 1'($urandom_range(0, 1));
            send(s, sb, model(s, sb));
        end
        rand_ordy = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", exp_q.size(), 0);

        // Directed backpressure: 10 stalled cycles with a competing in_valid.
        out_ready = 1'b0;
        s = {$urandom, $urandom, $urandom, $urandom};
        e = model(s, 1'b1);
        send(s, 1'b1, e);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_state", out_state, e);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_single_transfer", exp_q.size(), 0);

        // Reset while cnt = 2 in SUB.
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_sub_en = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_sub_out_valid", out_valid, 0);
        check("rst_sub_out_state", out_state, 0);
        check("rst_sub_in_ready", in_ready, 1);
        reset = 1'b0;
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, 1'b1, model(s, 1'b1));
        @(posedge clk); #1;

        // Reset while in DONE with out_ready high.
        out_ready = 1'b0;
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, 1'b0, model(s, 1'b0));
        reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_done_out_valid", out_valid, 0);
        check("rst_done_out_state", out_state, 0);
        check("rst_done_in_ready", in_ready, 1);
        reset = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, 1'b0, model(s, 1'b0));
        @(posedge clk); #1;

        // LANES sweep on the auxiliary instances.
        for (int sc = 0; sc < 2; sc++) begin
            sw_st  = (sc == 0) ? 128'h000102030405060708090a0b0c0d0e0f : {16{8'h63}};
            sw_sub = (sc == 1);
            e      = (sc == 0) ? 128'h000d0a0704010e0b0805020f0c090603 : 128'h0;
            for (int g = 0; g < 4; g++) begin
                check($sformatf("sweep_idle_L%0d", SW_L[g]), sw_irdy[g], 1);
                sw_lat[g] = 0;
                sw_got[g] = '0;
            end
            sw_vld = 1'b1;
            @(posedge clk); #1;
            sw_vld = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); #1;
                for (int g = 0; g < 4; g++) begin
                    if (sw_ovld[g] && sw_lat[g] == 0) begin
                        sw_lat[g] = k;
                        sw_got[g] = sw_out[g];
                    end
                end
            end
            for (int g = 0; g < 4; g++) begin
                check($sformatf("sweep_lat_L%0d", SW_L[g]), sw_lat[g], 16 / SW_L[g]);
                check($sformatf("sweep_data_L%0d", SW_L[g]), sw_got[g], e);
            end
        end

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
